// File: rtl/color_pkg.sv
// Shared colour encoding and scanner state type for the parcel colour path.
// The colour codes match the parcel_color select of color_filter.
package color_pkg;

  typedef enum logic [2:0] {
    COLOR_NONE  = 3'd0,
    COLOR_RED   = 3'd1,
    COLOR_GREEN = 3'd2,
    COLOR_BLUE  = 3'd3
  } color_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_ACCUM    = 3'd2,
    S_DECIDE   = 3'd3,
    S_REPORT   = 3'd4
  } scan_state_t;

  // color_filter drives 15 for a matching pixel; anything else is a miss.
  localparam logic [3:0] HIT_PIXEL = 4'd15;

endpackage

// File: rtl/color_max3.sv
// Combinational 3-way unsigned maximum over the red/green/blue hit counts.
// Ties resolve toward the lower colour code (red over green over blue).
module color_max3
  import color_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] hit_r_i,
  input  logic [W-1:0] hit_g_i,
  input  logic [W-1:0] hit_b_i,
  output logic [2:0]   win_color_o,
  output logic [W-1:0] win_count_o
);

  logic [2:0]   best_color;
  logic [W-1:0] best_count;

  // Strict greater-than keeps the earlier (higher priority) colour on ties.
  always_comb begin
    best_color = COLOR_RED;
    best_count = hit_r_i;
    if (hit_g_i > best_count) begin
      best_color = COLOR_GREEN;
      best_count = hit_g_i;
    end
    if (hit_b_i > best_count) begin
      best_color = COLOR_BLUE;
      best_count = hit_b_i;
    end
  end

  assign win_color_o = best_color;
  assign win_count_o = best_count;

endmodule

// File: rtl/parcel_color_scanner.sv
// Steps color_filter through red, green and blue frames, counts filter hits
// per frame and reports the dominant parcel colour to the sorter.
module parcel_color_scanner
  import color_pkg::*;
#(
  parameter int FRAME_PIXELS = 76800,
  parameter int MIN_HITS     = 256,
  parameter int COUNT_W      = $clog2(FRAME_PIXELS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               sof_i,
  input  logic               pix_valid_i,
  input  logic [3:0]         filt_pixel_i,
  output logic [2:0]         filt_color_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         result_color_o,
  output logic [COUNT_W-1:0] result_count_o
);

  localparam logic [COUNT_W-1:0] FRAME_C    = COUNT_W'(FRAME_PIXELS);
  localparam logic [COUNT_W-1:0] MIN_HITS_C = COUNT_W'(MIN_HITS);

  scan_state_t        state_q, state_d;
  color_t             cur_q, cur_d;
  logic [COUNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [COUNT_W-1:0] pix_cnt_inc;
  logic               hit_pix;
  logic               clr_all;
  logic               hit_reload;
  logic               hit_inc;
  logic [COUNT_W-1:0] hit_cnt [3];

  logic [2:0]         max_color;
  logic [COUNT_W-1:0] max_count;
  logic [2:0]         win_color_q, win_color_d;
  logic [COUNT_W-1:0] win_count_q, win_count_d;
  logic [2:0]         result_color_q;
  logic [COUNT_W-1:0] result_count_q;
  logic               done_q;

  assign hit_pix     = pix_valid_i && (filt_pixel_i == HIT_PIXEL);
  assign pix_cnt_inc = pix_cnt_q + 1'b1;

  // Next-state, counter control and colour select for the scan sequencer.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    pix_cnt_d    = pix_cnt_q;
    clr_all      = 1'b0;
    hit_reload   = 1'b0;
    hit_inc      = 1'b0;
    filt_color_o = COLOR_NONE;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cur_d     = COLOR_RED;
          pix_cnt_d = '0;
          clr_all   = 1'b1;
          state_d   = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        filt_color_o = cur_q;
        if (sof_i) begin
          // The sof cycle carries the first pixel of the frame.
          hit_reload = 1'b1;
          pix_cnt_d  = pix_valid_i ? COUNT_W'(1) : '0;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        filt_color_o = cur_q;
        if (sof_i) begin
          // Early sof means the previous frame was short: start this colour over.
          hit_reload = 1'b1;
          pix_cnt_d  = pix_valid_i ? COUNT_W'(1) : '0;
        end else if (pix_valid_i) begin
          pix_cnt_d = pix_cnt_inc;
          hit_inc   = hit_pix;
          if (pix_cnt_inc == FRAME_C) begin
            case (cur_q)
              COLOR_RED:   begin cur_d = COLOR_GREEN; state_d = S_WAIT_SOF; end
              COLOR_GREEN: begin cur_d = COLOR_BLUE;  state_d = S_WAIT_SOF; end
              default:     state_d = S_DECIDE;
            endcase
          end
        end
      end
      S_DECIDE: state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer state, current colour and frame pixel counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_q     <= COLOR_NONE;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // One saturating hit counter per colour; only the active colour's counter moves.
  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    logic               sel;
    logic [COUNT_W-1:0] cnt_q;

    assign sel         = (cur_q == color_t'(3'(gi + 1)));
    assign hit_cnt[gi] = cnt_q;

    // Clear on scan start, reload on sof, count hits without wrapping.
    always_ff @(posedge clk) begin
      if (rst || clr_all) begin
        cnt_q <= '0;
      end else if (sel && hit_reload) begin
        cnt_q <= hit_pix ? COUNT_W'(1) : '0;
      end else if (sel && hit_inc && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  color_max3 #(
    .W (COUNT_W)
  ) u_max3 (
    .hit_r_i     (hit_cnt[0]),
    .hit_g_i     (hit_cnt[1]),
    .hit_b_i     (hit_cnt[2]),
    .win_color_o (max_color),
    .win_count_o (max_count)
  );

  assign win_color_d = (max_count > MIN_HITS_C) ? max_color : COLOR_NONE;
  assign win_count_d = (max_count > MIN_HITS_C) ? max_count : '0;

  // Capture the thresholded winner in DECIDE, publish it with done in REPORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_color_q    <= COLOR_NONE;
      win_count_q    <= '0;
      result_color_q <= COLOR_NONE;
      result_count_q <= '0;
      done_q         <= 1'b0;
    end else begin
      if (state_q == S_DECIDE) begin
        win_color_q <= win_color_d;
        win_count_q <= win_count_d;
      end
      if (state_q == S_REPORT) begin
        result_color_q <= win_color_q;
        result_count_q <= win_count_q;
      end
      done_q <= (state_q == S_REPORT);
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign result_color_o = result_color_q;
  assign result_count_o = result_count_q;

endmodule

// File: tb/tb_parcel_color_scanner.sv
// Directed bench for parcel_color_scanner with 16-pixel frames and a hit threshold of 4.
module tb_parcel_color_scanner;

  localparam int FP = 16;
  localparam int MH = 4;
  localparam int CW = $clog2(FP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          sof_i = 1'b0;
  logic          pix_valid_i = 1'b0;
  logic [3:0]    filt_pixel_i = 4'd0;
  logic [2:0]    filt_color_o;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    result_color_o;
  logic [CW-1:0] result_count_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parcel_color_scanner #(
    .FRAME_PIXELS (FP),
    .MIN_HITS     (MH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .sof_i          (sof_i),
    .pix_valid_i    (pix_valid_i),
    .filt_pixel_i   (filt_pixel_i),
    .filt_color_o   (filt_color_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .result_color_o (result_color_o),
    .result_count_o (result_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invalid cycles carry a hit value so any missing pix_valid gating shows up.
  task automatic idle_inputs();
    sof_i        = 1'b0;
    pix_valid_i  = 1'b0;
    filt_pixel_i = 4'd15;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Hits occupy the first pixels; misses alternate 0 and 7 (7 must not count).
  task automatic send_frame(input int npix, input int hits, input bit gaps, input int start_at);
    for (int i = 0; i < npix; i++) begin
      if (gaps && (i % 4 == 2)) begin
        idle_inputs();
        step();
      end
      sof_i        = (i == 0);
      pix_valid_i  = 1'b1;
      filt_pixel_i = (i < hits) ? 4'd15 : ((i % 2 == 1) ? 4'd7 : 4'd0);
      start_i      = (i == start_at);
      step();
    end
    start_i = 1'b0;
    idle_inputs();
  endtask

  // Entered one cycle after the edge that sampled the last blue pixel.
  task automatic finish_scan(input string tag, input int ec, input int en);
    chk({tag, " done@+0"}, 32'(done_o), 0);
    step();
    chk({tag, " done@+1"}, 32'(done_o), 0);
    step();
    chk({tag, " done@+2"}, 32'(done_o), 1);
    chk({tag, " result_color"}, 32'(result_color_o), 32'(ec));
    chk({tag, " result_count"}, 32'(result_count_o), 32'(en));
    chk({tag, " filt_color end"}, 32'(filt_color_o), 0);
    chk({tag, " busy end"}, 32'(busy_o), 0);
    step();
    chk({tag, " done pulse width"}, 32'(done_o), 0);
    chk({tag, " result hold"}, 32'(result_color_o), 32'(ec));
  endtask

  task automatic scan(input string tag, input int hr, input int hg, input int hb,
                      input int g_short, input bit gaps, input int ec, input int en);
    pulse_start();
    chk({tag, " busy"}, 32'(busy_o), 1);
    chk({tag, " filt_color red"}, 32'(filt_color_o), 1);
    // Valid hit pixels before sof must be ignored.
    pix_valid_i  = 1'b1;
    filt_pixel_i = 4'd15;
    step();
    step();
    idle_inputs();
    send_frame(FP, hr, gaps, -1);
    chk({tag, " filt_color green"}, 32'(filt_color_o), 2);
    if (g_short >= 0) send_frame(9, g_short, 1'b0, -1);
    send_frame(FP, hg, gaps, -1);
    chk({tag, " filt_color blue"}, 32'(filt_color_o), 3);
    send_frame(FP, hb, gaps, -1);
    finish_scan(tag, ec, en);
  endtask

  initial begin
    int dones;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", 32'(busy_o), 0);
    chk("reset done", 32'(done_o), 0);
    chk("reset filt_color", 32'(filt_color_o), 0);
    chk("reset result_color", 32'(result_color_o), 0);
    chk("reset result_count", 32'(result_count_o), 0);

    // Reset in the middle of the red frame.
    pulse_start();
    send_frame(5, 3, 1'b0, -1);
    chk("pre-reset busy", 32'(busy_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midscan reset busy", 32'(busy_o), 0);
    chk("midscan reset filt_color", 32'(filt_color_o), 0);
    chk("midscan reset done", 32'(done_o), 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) dones++;
      step();
    end
    chk("no done after reset", 32'(dones), 0);

    scan("basic", 10, 3, 2, -1, 1'b0, 1, 10);
    scan("tie", 7, 7, 5, -1, 1'b0, 1, 7);
    scan("below min", 2, 4, 3, -1, 1'b0, 0, 0);
    scan("short frame", 5, 6, 2, 5, 1'b1, 2, 6);

    // Extra start pulses while busy must not restart or double the scan.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      start_i = (i == 1);
      step();
    end
    start_i = 1'b0;
    chk("stall filt_color", 32'(filt_color_o), 1);
    chk("stall busy", 32'(busy_o), 1);
    send_frame(FP, 6, 1'b0, 8);
    send_frame(FP, 2, 1'b0, 3);
    send_frame(FP, 1, 1'b0, -1);
    finish_scan("busy start", 1, 6);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) dones++;
      step();
    end
    chk("single done", 32'(dones), 0);
    chk("idle after scan", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
